alu_mc: RTL and testbench

Multi-cycle, registered successor to the combinational ALU; it keeps the existing 4-bit opcode map for opcodes 0000–1001.
- Adds carry/zero/negative flags, carry-chained ADC/SBB, iterative rotates by N, and an optional shift-add multiplier.
- Sits between the register file and the write-back mux.
- The control unit issues IN_START, waits for OUT_DONE, and stalls while OUT_BUSY is high.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_seq.sv | 76 +++++++
 rtl/alu_mc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_mc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU (alu_mc) and its
// sequential multiplier (alu_mul_seq).
//   - 4-bit opcode map OP_NOT .. OP_ROL
//   - FSM state encoding for alu_mc
//   - bit positions of the carry/zero/negative flags in the flag vector
package alu_pkg;

    localparam logic [3:0] OP_NOT  = 4'h0;
    localparam logic [3:0] OP_XOR  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_RR   = 4'h6;
    localparam logic [3:0] OP_RL   = 4'h7;
    localparam logic [3:0] OP_DEC  = 4'h8;
    localparam logic [3:0] OP_INC  = 4'h9;
    localparam logic [3:0] OP_ADC  = 4'hA;
    localparam logic [3:0] OP_SBB  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_MULH = 4'hD;
    localparam logic [3:0] OP_ROR  = 4'hE;
    localparam logic [3:0] OP_ROL  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial product
// per clock, WIDTH steps per multiply.
// Ports:
//   CLK   - clock, rising edge
//   RST   - synchronous active-high reset
//   START - load A/B and begin a multiply
//   A, B  - operands, sampled on the START edge
//   P     - product after the step taken this cycle (final when DONE=1)
//   DONE  - high during the cycle whose closing edge completes the last step,
//           so the parent can register P on that same edge
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 DONE
);
    import alu_pkg::*;

    localparam int CWIDTH = $clog2(WIDTH);

    logic                busy_q, busy_d;
    logic [CWIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic [2*WIDTH-1:0]  prod_step;
    logic [WIDTH:0]      partial;

    // The product register holds {high accumulator, remaining multiplier bits}.
    // Each step adds A into the high half when the current multiplier LSB is
    // set, then shifts the whole thing right one place, pulling the adder's
    // carry into the top bit. After WIDTH steps it holds the full product.
    always_comb begin
        partial   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_step = {partial, prod_q[WIDTH-1:1]};
        P         = prod_step;
        DONE      = busy_q && (cnt_q == CWIDTH'(WIDTH - 1));

        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        prod_d = prod_q;
        if (START) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            a_d    = A;
            prod_d = {{WIDTH{1'b0}}, B};
        end else if (busy_q) begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CWIDTH'(1);
            if (DONE) begin
                busy_d = 1'b0;
            end
        end
    end

    // Plain state register; reset clears any multiply in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            prod_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            prod_q <= prod_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with carry/zero/negative flags.
// Single-cycle logic/arithmetic ops, carry-chained ADC/SBB, rotates by N
// (one bit per clock), and an optional sequential multiplier.
// Optional feature macro: ALU_MC_MUL_EN enables MUL/MULH (1100/1101) via
// alu_mul_seq; without it those opcodes pass IN_B like any unlisted opcode.
// Ports:
//   CLK, RST          - clock, synchronous active-high reset
//   IN_START          - start request, honoured only while idle
//   IN_INSTR          - opcode
//   IN_A, IN_B        - operands; IN_B[SWIDTH-1:0] is the rotate amount
//   OUT               - registered result, held until the next DONE
//   OUT_C/OUT_Z/OUT_N - carry/borrow/shift-out, zero, negative flags
//   OUT_BUSY          - multi-cycle operation in progress
//   OUT_DONE          - one-cycle pulse when OUT and flags were just updated
module alu_mc #(
    parameter int DWIDTH = 8,
    parameter int IWIDTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_START,
    input  logic [IWIDTH-1:0] IN_INSTR,
    input  logic [DWIDTH-1:0] IN_A,
    input  logic [DWIDTH-1:0] IN_B,
    output logic [DWIDTH-1:0] OUT,
    output logic              OUT_C,
    output logic              OUT_Z,
    output logic              OUT_N,
    output logic              OUT_BUSY,
    output logic              OUT_DONE
);
    import alu_pkg::*;

    localparam int SWIDTH = $clog2(DWIDTH);

    state_t                 state_q, state_d;
    logic [DWIDTH-1:0]      out_q, out_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [IWIDTH-1:0]      op_q, op_d;
    logic [DWIDTH-1:0]      rot_q, rot_d;
    logic [SWIDTH-1:0]      cnt_q, cnt_d;

    logic [DWIDTH:0]        wide;
    logic [DWIDTH:0]        c_ext;
    logic [DWIDTH:0]        one_ext;
    logic [DWIDTH-1:0]      sc_res;
    logic                   sc_c;
    logic                   fin;
    logic [DWIDTH-1:0]      fin_res;
    logic                   fin_c;
    logic                   step_bit;

`ifdef ALU_MC_MUL_EN
    logic                   mul_start;
    logic [2*DWIDTH-1:0]    mul_p;
    logic                   mul_done;

    alu_mul_seq #(
        .WIDTH (DWIDTH)
    ) u_mul (
        .CLK   (CLK),
        .RST   (RST),
        .START (mul_start),
        .A     (IN_A),
        .B     (IN_B),
        .P     (mul_p),
        .DONE  (mul_done)
    );
`endif

    assign c_ext   = {{DWIDTH{1'b0}}, flags_q[FLAG_C]};
    assign one_ext = {{DWIDTH{1'b0}}, 1'b1};

    // Result and carry for every single-cycle opcode straight from the
    // inputs. Arithmetic is done one bit wider than the data so the top bit
    // is the carry out, or the borrow for subtractions (a negative
    // difference wraps and sets it).
    always_comb begin
        wide   = '0;
        sc_res = IN_B;
        sc_c   = 1'b0;
        case (IN_INSTR)
            OP_NOT: sc_res = ~IN_A;
            OP_XOR: sc_res = IN_A ^ IN_B;
            OP_OR:  sc_res = IN_A | IN_B;
            OP_AND: sc_res = IN_A & IN_B;
            OP_SUB: begin
                wide   = {1'b0, IN_A} - {1'b0, IN_B};
                sc_res = wide[DWIDTH-1:0];
                sc_c   = wide[DWIDTH];
            end
            OP_ADD: begin
                wide   = {1'b0, IN_A} + {1'b0, IN_B};
                sc_res = wide[DWIDTH-1:0];
                sc_c   = wide[DWIDTH];
            end
            OP_RR: begin
                sc_res = {1'b0, IN_A[DWIDTH-1:1]};
                sc_c   = IN_A[0];
            end
            OP_RL: begin
                sc_res = {IN_A[DWIDTH-2:0], 1'b0};
                sc_c   = IN_A[DWIDTH-1];
            end
            OP_DEC: begin
                wide   = {1'b0, IN_A} - one_ext;
                sc_res = wide[DWIDTH-1:0];
                sc_c   = wide[DWIDTH];
            end
            OP_INC: begin
                wide   = {1'b0, IN_A} + one_ext;
                sc_res = wide[DWIDTH-1:0];
                sc_c   = wide[DWIDTH];
            end
            OP_ADC: begin
                wide   = {1'b0, IN_A} + {1'b0, IN_B} + c_ext;
                sc_res = wide[DWIDTH-1:0];
                sc_c   = wide[DWIDTH];
            end
            OP_SBB: begin
                wide   = {1'b0, IN_A} - {1'b0, IN_B} - c_ext;
                sc_res = wide[DWIDTH-1:0];
                sc_c   = wide[DWIDTH];
            end
            default: begin
                sc_res = IN_B;
                sc_c   = 1'b0;
            end
        endcase
    end

    // Controller next-state. In IDLE a start either finishes immediately
    // (single-cycle ops, zero-length rotates) or launches a rotate/multiply.
    // Whichever path completes an operation raises fin with its result and
    // carry; the shared tail then updates OUT, all three flags and DONE
    // together so they can never disagree.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        flags_d  = flags_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        op_d     = op_q;
        rot_d    = rot_q;
        cnt_d    = cnt_q;
        fin      = 1'b0;
        fin_res  = out_q;
        fin_c    = 1'b0;
        step_bit = 1'b0;
`ifdef ALU_MC_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (IN_START) begin
                    if (IN_INSTR == OP_ROR || IN_INSTR == OP_ROL) begin
                        if (IN_B[SWIDTH-1:0] == '0) begin
                            fin     = 1'b1;
                            fin_res = IN_A;
                            fin_c   = 1'b0;
                        end else begin
                            state_d = ST_ROT;
                            busy_d  = 1'b1;
                            op_d    = IN_INSTR;
                            rot_d   = IN_A;
                            cnt_d   = IN_B[SWIDTH-1:0];
                        end
                    end
`ifdef ALU_MC_MUL_EN
                    else if (IN_INSTR == OP_MUL || IN_INSTR == OP_MULH) begin
                        state_d   = ST_MUL;
                        busy_d    = 1'b1;
                        op_d      = IN_INSTR;
                        mul_start = 1'b1;
                    end
`endif
                    else begin
                        fin     = 1'b1;
                        fin_res = sc_res;
                        fin_c   = sc_c;
                    end
                end
            end
            ST_ROT: begin
                if (op_q == OP_ROL) begin
                    rot_d    = {rot_q[DWIDTH-2:0], rot_q[DWIDTH-1]};
                    step_bit = rot_q[DWIDTH-1];
                end else begin
                    rot_d    = {rot_q[0], rot_q[DWIDTH-1:1]};
                    step_bit = rot_q[0];
                end
                cnt_d = cnt_q - SWIDTH'(1);
                if (cnt_q == SWIDTH'(1)) begin
                    state_d = ST_IDLE;
                    fin     = 1'b1;
                    fin_res = rot_d;
                    fin_c   = step_bit;
                end else begin
                    busy_d = 1'b1;
                end
            end
`ifdef ALU_MC_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_IDLE;
                    fin     = 1'b1;
                    if (op_q == OP_MULH) begin
                        fin_res = mul_p[2*DWIDTH-1:DWIDTH];
                        fin_c   = 1'b0;
                    end else begin
                        fin_res = mul_p[DWIDTH-1:0];
                        fin_c   = |mul_p[2*DWIDTH-1:DWIDTH];
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            out_d           = fin_res;
            flags_d[FLAG_C] = fin_c;
            flags_d[FLAG_Z] = (fin_res == '0);
            flags_d[FLAG_N] = fin_res[DWIDTH-1];
            done_d          = 1'b1;
        end
    end

    // Single state register for the controller and all registered outputs;
    // reset aborts any operation in flight without a DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= '0;
            rot_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            op_q    <= op_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
        end
    end

    assign OUT      = out_q;
    assign OUT_C    = flags_q[FLAG_C];
    assign OUT_Z    = flags_q[FLAG_Z];
    assign OUT_N    = flags_q[FLAG_N];
    assign OUT_BUSY = busy_q;
    assign OUT_DONE = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc at DWIDTH=8.
// Expected results come from an integer-arithmetic model of the opcode
// table; define ALU_MC_MUL_EN here too when building the multiplier variant.
module tb_alu_mc;

    logic       CLK;
    logic       RST;
    logic       IN_START;
    logic [3:0] IN_INSTR;
    logic [7:0] IN_A;
    logic [7:0] IN_B;
    logic [7:0] OUT;
    logic       OUT_C;
    logic       OUT_Z;
    logic       OUT_N;
    logic       OUT_BUSY;
    logic       OUT_DONE;

    int passCount  = 0;
    int checkCount = 0;
    int mC         = 0;

    alu_mc #(
        .DWIDTH (8),
        .IWIDTH (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_START (IN_START),
        .IN_INSTR (IN_INSTR),
        .IN_A     (IN_A),
        .IN_B     (IN_B),
        .OUT      (OUT),
        .OUT_C    (OUT_C),
        .OUT_Z    (OUT_Z),
        .OUT_N    (OUT_N),
        .OUT_BUSY (OUT_BUSY),
        .OUT_DONE (OUT_DONE)
    );

    // Free-running 10-unit clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Opcode table in plain integer arithmetic. lat is the number of edges
    // after the start edge before DONE appears (0 for single-cycle ops).
    task automatic modelOp(input int op, input int a, input int b, input int cin,
                           output int r, output int c, output int lat);
        int n;
        int p;
        r = b; c = 0; lat = 0;
        case (op)
            0:  r = (~a) & 255;
            1:  r = a ^ b;
            2:  r = a | b;
            3:  r = a & b;
            4:  begin r = (a - b) & 255;       c = (a < b) ? 1 : 0; end
            5:  begin r = (a + b) & 255;       c = (a + b > 255) ? 1 : 0; end
            6:  begin r = a / 2;               c = a % 2; end
            7:  begin r = (a * 2) & 255;       c = a / 128; end
            8:  begin r = (a - 1) & 255;       c = (a == 0) ? 1 : 0; end
            9:  begin r = (a + 1) & 255;       c = (a == 255) ? 1 : 0; end
            10: begin r = (a + b + cin) & 255; c = (a + b + cin > 255) ? 1 : 0; end
            11: begin r = (a - b - cin) & 255; c = (a < b + cin) ? 1 : 0; end
`ifdef ALU_MC_MUL_EN
            12: begin p = a * b; r = p % 256; c = (p / 256 != 0) ? 1 : 0; lat = 8; end
            13: begin p = a * b; r = p / 256; c = 0; lat = 8; end
`endif
            14, 15: begin
                n = b % 8;
                if (n == 0) begin
                    r = a;
                end else if (op == 15) begin
                    r = ((a << n) | (a >> (8 - n))) & 255;
                    c = r % 2;
                    lat = n;
                end else begin
                    r = ((a >> n) | (a << (8 - n))) & 255;
                    c = r / 128;
                    lat = n;
                end
            end
            default: r = b;
        endcase
    endtask

    // Issue one operation, scramble the inputs after the start edge, wait
    // (bounded) for DONE and compare result, flags, latency and pulse width.
    task automatic applyStimulus(input int op, input int a, input int b, input bit poke);
        int er, ec, el, cycles;
        modelOp(op, a, b, mC, er, ec, el);
        @(negedge CLK);
        IN_INSTR = op[3:0]; IN_A = a[7:0]; IN_B = b[7:0]; IN_START = 1'b1;
        @(posedge CLK); #1;
        IN_START = 1'b0; IN_INSTR = 4'($urandom); IN_A = 8'($urandom); IN_B = 8'($urandom);
        cycles = 0;
        while (OUT_DONE !== 1'b1 && cycles < el + 3) begin
            checkOutput("busyWhileRunning", OUT_BUSY, 1);
            if (poke && cycles == 0) begin
                @(negedge CLK);
                IN_START = 1'b1; IN_INSTR = 4'h5;
                @(posedge CLK); #1;
                IN_START = 1'b0;
            end else begin
                @(posedge CLK); #1;
            end
            cycles++;
        end
        checkOutput("latency", cycles, el);
        checkOutput("done", OUT_DONE, 1);
        checkOutput("busyAtDone", OUT_BUSY, 0);
        checkOutput("out", OUT, er);
        checkOutput("flagC", OUT_C, ec);
        checkOutput("flagZ", OUT_Z, (er == 0) ? 1 : 0);
        checkOutput("flagN", OUT_N, er / 128);
        mC = ec;
        @(posedge CLK); #1;
        checkOutput("donePulse", OUT_DONE, 0);
        checkOutput("outHeld", OUT, er);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "Out"}, OUT, 0);
        checkOutput({tag, "C"}, OUT_C, 0);
        checkOutput({tag, "Z"}, OUT_Z, 0);
        checkOutput({tag, "N"}, OUT_N, 0);
        checkOutput({tag, "Busy"}, OUT_BUSY, 0);
        checkOutput({tag, "Done"}, OUT_DONE, 0);
    endtask

    // Start a multi-cycle op and hit reset in its second busy cycle.
    task automatic abortOp(input int op, input int a, input int b);
        @(negedge CLK);
        IN_INSTR = op[3:0]; IN_A = a[7:0]; IN_B = b[7:0]; IN_START = 1'b1;
        @(posedge CLK); #1;
        IN_START = 1'b0;
        checkOutput("abortBusy1", OUT_BUSY, 1);
        @(posedge CLK); #1;
        checkOutput("abortBusy2", OUT_BUSY, 1);
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        checkReset("abort");
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        checkOutput("abortNoDone", OUT_DONE, 0);
        checkOutput("abortIdle", OUT_BUSY, 0);
        mC = 0;
        applyStimulus(5, 'h12, 'h34, 1'b0);
    endtask

    initial begin
        int er, ec, el;
        RST = 1'b1; IN_START = 1'b0; IN_INSTR = 4'h0; IN_A = 8'h00; IN_B = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        checkReset("reset");
        @(negedge CLK); RST = 1'b0;
        mC = 0;

        // Carry chain
        applyStimulus(5, 'hF0, 'h20, 1'b0);
        checkOutput("addCarryConst", OUT_C, 1);
        applyStimulus(10, 'h00, 'h00, 1'b0);
        checkOutput("adcConst", OUT, 'h01);

        // Borrow chain
        applyStimulus(4, 'h05, 'h05, 1'b0);
        applyStimulus(4, 'h00, 'h01, 1'b0);
        applyStimulus(11, 'h10, 'h00, 1'b0);
        checkOutput("sbbConst", OUT, 'h0F);

        // Rotates, with a start poked while busy
        applyStimulus(15, 'h81, 'h03, 1'b1);
        checkOutput("rolConst", OUT, 'h0C);
        applyStimulus(14, 'hA5, 'h08, 1'b0);
        applyStimulus(14, 'h01, 'h07, 1'b1);

        // Multiply (or pass-through of IN_B without the multiplier)
        applyStimulus(12, 'h10, 'h11, 1'b0);
        applyStimulus(13, 'h10, 'h11, 1'b0);
        applyStimulus(12, 'hFF, 'hFF, 1'b1);

        // Reset mid-operation
        abortOp(15, 'h3C, 'h07);
`ifdef ALU_MC_MUL_EN
        abortOp(12, 'h10, 'h11);
`endif

        // Back-to-back: START stays high through INC's DONE cycle
        modelOp(9, 'hFF, 0, mC, er, ec, el);
        @(negedge CLK);
        IN_INSTR = 4'h9; IN_A = 8'hFF; IN_B = 8'h00; IN_START = 1'b1;
        @(posedge CLK); #1;
        checkOutput("b2bDone1", OUT_DONE, 1);
        checkOutput("b2bOut1", OUT, er);
        checkOutput("b2bC1", OUT_C, ec);
        checkOutput("b2bZ1", OUT_Z, 1);
        mC = ec;
        modelOp(5, 'h01, 'h02, mC, er, ec, el);
        IN_INSTR = 4'h5; IN_A = 8'h01; IN_B = 8'h02;
        @(posedge CLK); #1;
        IN_START = 1'b0;
        checkOutput("b2bDone2", OUT_DONE, 1);
        checkOutput("b2bOut2", OUT, er);
        checkOutput("b2bC2", OUT_C, ec);
        mC = ec;

        // Random operations
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), (i % 5) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
